// File: rtl/pstack_ctrl_pkg.sv
// Shared constants for the predicate-stack divergence controller:
// FSM encodings, phase bit values and the event-priority helper.
package pstack_ctrl_pkg;

    localparam int N_CORES_DEF  = 4;
    localparam int PS_DEPTH_DEF = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PUSH  = 3'd1;
    localparam logic [2:0] ST_CHK_T = 3'd2;
    localparam logic [2:0] ST_COMP  = 3'd3;
    localparam logic [2:0] ST_CHK_E = 3'd4;
    localparam logic [2:0] ST_POP   = 3'd5;

    localparam logic PHASE_THEN = 1'b0;
    localparam logic PHASE_ELSE = 1'b1;

    typedef enum logic [1:0] {
        EV_NONE = 2'd0,
        EV_BR   = 2'd1,
        EV_ELSE = 2'd2,
        EV_JOIN = 2'd3
    } event_e;

    // Join beats else beats branch when several events arrive together.
    function automatic event_e pick_event(input logic br, input logic el, input logic jn);
        if (jn)      return EV_JOIN;
        else if (el) return EV_ELSE;
        else if (br) return EV_BR;
        else         return EV_NONE;
    endfunction

endpackage

// File: rtl/pstack_depth_ctr.sv
// Saturating up/down nesting-depth counter with full/empty flags.
module pstack_depth_ctr #(
    parameter int MAX = 8,
    parameter int DW  = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [DW-1:0] cnt_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [DW-1:0] cnt_q, cnt_d;

    assign full_o  = (cnt_q == DW'(MAX));
    assign empty_o = (cnt_q == '0);
    assign cnt_o   = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && !full_o)
            cnt_d = cnt_q + DW'(1);
        else if (dec_i && !inc_i && !empty_o)
            cnt_d = cnt_q - DW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/pstack_ctrl.sv
// Divergence controller: turns sequencer branch/else/join events into single-cycle
// pstack push/comp/pop strobes and flags empty paths so the sequencer can skip them.
module pstack_ctrl
    import pstack_ctrl_pkg::*;
#(
    parameter int N_CORES  = N_CORES_DEF,
    parameter int PS_DEPTH = PS_DEPTH_DEF,
    parameter int DW       = $clog2(PS_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               br_valid,
    input  logic [N_CORES-1:0] br_pred,
    input  logic               else_hit,
    input  logic               join_hit,
    input  logic [N_CORES-1:0] ps_q,
    output logic [N_CORES-1:0] ps_d,
    output logic               ps_push,
    output logic               ps_pop,
    output logic               ps_comp,
    output logic               busy,
    output logic               skip_then,
    output logic               skip_else,
    output logic [DW-1:0]      depth,
    output logic               err
);

    logic [2:0]          state_q, state_d;
    logic [N_CORES-1:0]  taken_q;
    logic [PS_DEPTH-1:0] phase_q, phase_d;
    logic                err_q, err_d;
    logic                top_phase;
    logic                full, empty;
    logic                dep_inc, dep_dec;
    logic                any_ev, multi_ev;
    event_e              win;

    pstack_depth_ctr #(.MAX(PS_DEPTH), .DW(DW)) u_depth (
        .clk     (clk),
        .rst_n   (reset),
        .inc_i   (dep_inc),
        .dec_i   (dep_dec),
        .cnt_o   (depth),
        .full_o  (full),
        .empty_o (empty)
    );

    assign win      = pick_event(br_valid, else_hit, join_hit);
    assign any_ev   = br_valid | else_hit | join_hit;
    assign multi_ev = (br_valid & else_hit) | (br_valid & join_hit) | (else_hit & join_hit);

    // Phase of the innermost open branch lives at index depth-1.
    always_comb begin
        top_phase = PHASE_THEN;
        for (int i = 0; i < PS_DEPTH; i++)
            if (depth == DW'(i + 1)) top_phase = phase_q[i];
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        phase_d = phase_q;
        dep_inc = 1'b0;
        dep_dec = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (multi_ev) err_d = 1'b1;
                case (win)
                    EV_JOIN: if (empty) err_d = 1'b1;
                             else       state_d = ST_POP;
                    EV_ELSE: if (empty || top_phase == PHASE_ELSE) err_d = 1'b1;
                             else                                  state_d = ST_COMP;
                    EV_BR:   if (full) err_d = 1'b1;
                             else      state_d = ST_PUSH;
                    default: ;
                endcase
            end
            ST_PUSH: begin
                dep_inc = 1'b1;
                for (int i = 0; i < PS_DEPTH; i++)
                    if (depth == DW'(i)) phase_d[i] = PHASE_THEN;
                state_d = ST_CHK_T;
            end
            ST_COMP: begin
                for (int i = 0; i < PS_DEPTH; i++)
                    if (depth == DW'(i + 1)) phase_d[i] = PHASE_ELSE;
                state_d = ST_CHK_E;
            end
            ST_POP: begin
                dep_dec = 1'b1;
                for (int i = 0; i < PS_DEPTH; i++)
                    if (depth == DW'(i + 1)) phase_d[i] = PHASE_THEN;
                state_d = ST_IDLE;
            end
            ST_CHK_T, ST_CHK_E: state_d = ST_IDLE;
            default:            state_d = ST_IDLE;
        endcase
        // The sequencer must hold events while busy; anything arriving is dropped.
        if (state_q != ST_IDLE && any_ev) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            err_q   <= err_d;
        end
    end

    // Mask data only reaches ps_d while in PUSH, so it needs no reset.
    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && win == EV_BR)
            taken_q <= br_pred & ps_q;
    end

    assign ps_push   = (state_q == ST_PUSH);
    assign ps_comp   = (state_q == ST_COMP);
    assign ps_pop    = (state_q == ST_POP);
    assign ps_d      = ps_push ? taken_q : '0;
    assign busy      = (state_q != ST_IDLE);
    assign skip_then = (state_q == ST_CHK_T) && (ps_q == '0);
    assign skip_else = (state_q == ST_CHK_E) && (ps_q == '0);
    assign err       = err_q;

endmodule

// File: doc/pstack_ctrl.md
Name: pstack_ctrl

Overview:
Divergence controller that drives the predicate stack (pstack) push/pop/comp interface and consumes its active-mask output q.
- Converts sequencer branch events (branch issued, else label reached, join reached) into single-cycle pstack commands.
- Tracks nesting depth and per-level then/else phase.
- Tells the sequencer when a path has no active cores, so that path can be skipped.
- Sits between the instruction sequencer and pstack in the scheduler.

Parameters:
N_CORES, `N_CORES (constants), number of lanes = mask width
PS_DEPTH, 8, pstack capacity in entries; must match the pstack instance
DW, $clog2(PS_DEPTH+1), depth counter width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
br_valid  input  1  1-cycle pulse: divergent branch issued
br_pred  input  N_CORES  per-core branch-taken predicate, valid with br_valid
else_hit  input  1  1-cycle pulse: PC reached else label of innermost branch
join_hit  input  1  1-cycle pulse: PC reached reconvergence point
ps_q  input  N_CORES  pstack q (current active mask)
ps_d  output  N_CORES  mask to push
ps_push  output  1  pstack push strobe
ps_pop  output  1  pstack pop strobe
ps_comp  output  1  pstack complement strobe
busy  output  1  controller mid-operation; sequencer holds events
skip_then  output  1  1-cycle pulse: taken mask empty, jump to else
skip_else  output  1  1-cycle pulse: else mask empty, jump to join
depth  output  DW  current nesting depth
err  output  1  sticky error (overflow/underflow/protocol); cleared only by reset

Behaviour:
- pstack contract: each strobe is exactly 1 cycle and is held while ps_d is stable.
  - push: new top = d.
  - comp: top = ~top & entry-below (else mask).
  - pop: remove top.
  - ps_q reflects the result on the cycle after the strobe.
- Reset (reset=0, async): state IDLE, all strobes 0, ps_d=0, depth=0, phase bits 0, busy=0, skip_*=0, err=0. Reset mid-operation aborts the command; no partial strobe is emitted after release.
- FSM states: IDLE, PUSH, CHK_T, COMP, CHK_E, POP.
- IDLE, br_valid (depth<PS_DEPTH):
  - Latch taken = br_pred & ps_q; go to PUSH.
  - PUSH: ps_push=1, ps_d=taken, depth+1, phase[depth]=THEN; go to CHK_T.
  - CHK_T: if ps_q==0, pulse skip_then; go to IDLE.
- IDLE, else_hit (depth>0, phase[top]=THEN): go to COMP.
  - COMP: ps_comp=1, phase[top]=ELSE; go to CHK_E.
  - CHK_E: if ps_q==0, pulse skip_else; go to IDLE.
- IDLE, join_hit (depth>0): go to POP.
  - POP: ps_pop=1, depth-1, phase[top] cleared; go to IDLE.
- Latency: event to strobe = 1 cycle; event to skip pulse = 2 cycles.
- busy=1 in every state except IDLE.
- Error conditions (set err; no strobe issued; remain in IDLE):
  - br_valid with depth==PS_DEPTH (overflow)
  - else_hit or join_hit with depth==0 (underflow)
  - else_hit with phase[top]==ELSE
  - any event while busy (event dropped)
- Simultaneous events in IDLE: priority join_hit > else_hit > br_valid. Only the winner executes; losers set err.
- ps_d returns to 0 in the cycle after PUSH.
- At most one strobe is high in any cycle.
- depth never wraps; it saturates at 0 and PS_DEPTH.

Decomposition:
- Shared constants (add to constants): FSM state encodings, PHASE_THEN=0 / PHASE_ELSE=1, PS_DEPTH default.
- Phase bits: a PS_DEPTH-bit register indexed by depth-1, kept inline.
- One natural sub-module: pstack_depth_ctr (saturating up/down counter with full/empty flags).

Test Plan:
- N_CORES=4, reset released with ps_q=1111.
  - br_valid, br_pred=1010: ps_push with ps_d=1010 one cycle later; depth=1.
  - Model returns q=1010: no skip_then.
- Continue: else_hit: ps_comp pulse; model q=0101; no skip_else.
  - join_hit: ps_pop; depth=0, busy=0.
- ps_q=1100, br_pred=0011: push ps_d=0000; skip_then pulse 2 cycles after br_valid.
  - Then else_hit with q becoming 1100: no skip_else.
- Nesting: 8 br_valid at depth 0..7 are accepted; the 9th gives no push and err=1, depth stays 8.
  - After reset, join_hit at depth 0 gives no pop and err=1.
- br_valid and join_hit in the same cycle at depth 1: only ps_pop issues; err=1.
  - br_valid during busy is dropped and sets err.
- Assert reset in the PUSH-pending cycle: all outputs go to 0 immediately; no strobe after release; depth=0.
